// File: rtl/fp16_fma_result_buffer.sv
// Credit-gated result buffer for a fixed-latency, non-stallable FP16 FMA pipeline.
// Issue credits guarantee a FIFO slot for every result; the FIFO presents results on valid/ready.
module fp16_fma_result_buffer #(
    parameter int DEPTH   = 8,
    parameter int LATENCY = 4,
    parameter int DATA_W  = 16,
    parameter int CNT_W   = $clog2(DEPTH + 1)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              issue_valid,
    output logic              issue_ready,
    output logic              fma_in_valid,
    input  logic              fma_out_valid,
    input  logic [DATA_W-1:0] fma_out,
    output logic              m_valid,
    output logic [DATA_W-1:0] m_data,
    input  logic              m_ready,
    output logic [CNT_W-1:0]  count,
    output logic [CNT_W-1:0]  inflight,
    output logic              err_overflow,
    output logic              err_unexpected
);

    localparam int PTR_W = $clog2(DEPTH);

    generate
        if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
            $error("DEPTH must be a power of two >= 2");
        end
        if (LATENCY < 1) begin : g_bad_latency
            $error("LATENCY must be at least 1");
        end
    endgenerate

    logic [DATA_W-1:0] mem [DEPTH];
    logic [PTR_W-1:0]  rd_ptr;
    logic [PTR_W-1:0]  wr_ptr;
    logic [CNT_W:0]    credit_sum;
    logic              full;
    logic              pop;
    logic              push_ok;
    logic              fire_i;

    // One extra bit on the credit sum so count+inflight can never wrap.
    always_comb begin
        credit_sum   = {1'b0, count} + {1'b0, inflight};
        issue_ready  = credit_sum < (CNT_W + 1)'(DEPTH);
        fire_i       = issue_valid & issue_ready;
        fma_in_valid = fire_i;
        m_valid      = (count != '0);
        full         = (count == CNT_W'(DEPTH));
        pop          = m_valid & m_ready;
        push_ok      = fma_out_valid & (~full | pop);
        m_data       = mem[rd_ptr];
    end

    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr] <= fma_out;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_ptr         <= '0;
            wr_ptr         <= '0;
            count          <= '0;
            inflight       <= '0;
            err_overflow   <= 1'b0;
            err_unexpected <= 1'b0;
        end else begin
            if (push_ok) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end

            case ({push_ok, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase

            // A return with nothing outstanding leaves inflight pinned at zero.
            case ({fire_i, fma_out_valid})
                2'b10: inflight <= inflight + 1'b1;
                2'b01: begin
                    if (inflight != '0) begin
                        inflight <= inflight - 1'b1;
                    end
                end
                default: inflight <= inflight;
            endcase

            if (fma_out_valid && full && !pop) begin
                err_overflow <= 1'b1;
            end
            if (fma_out_valid && inflight == '0) begin
                err_unexpected <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_fp16_fma_result_buffer.sv
// Directed bench for fp16_fma_result_buffer: a LATENCY-cycle FMA model feeds the DUT,
// and a scoreboard queue of accepted results is checked against every pop.
module tb_fp16_fma_result_buffer;

    localparam int DEPTH   = 8;
    localparam int LATENCY = 4;
    localparam int DATA_W  = 16;
    localparam int CNT_W   = $clog2(DEPTH + 1);

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              issue_valid = 1'b0;
    logic              issue_ready;
    logic              fma_in_valid;
    logic              fma_out_valid = 1'b0;
    logic [DATA_W-1:0] fma_out = '0;
    logic              m_valid;
    logic [DATA_W-1:0] m_data;
    logic              m_ready = 1'b0;
    logic [CNT_W-1:0]  count;
    logic [CNT_W-1:0]  inflight;
    logic              err_overflow;
    logic              err_unexpected;

    fp16_fma_result_buffer #(
        .DEPTH   (DEPTH),
        .LATENCY (LATENCY),
        .DATA_W  (DATA_W)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .issue_valid    (issue_valid),
        .issue_ready    (issue_ready),
        .fma_in_valid   (fma_in_valid),
        .fma_out_valid  (fma_out_valid),
        .fma_out        (fma_out),
        .m_valid        (m_valid),
        .m_data         (m_data),
        .m_ready        (m_ready),
        .count          (count),
        .inflight       (inflight),
        .err_overflow   (err_overflow),
        .err_unexpected (err_unexpected)
    );

    always #5 clk = ~clk;

    int                tests = 0;
    int                fails = 0;
    logic [DATA_W-1:0] exp_q[$];
    logic              pipe_v[LATENCY];
    logic [DATA_W-1:0] pipe_d[LATENCY];
    logic              mdl_v;
    logic [DATA_W-1:0] mdl_d;
    logic              inj_v   = 1'b0;
    logic              inj_acc = 1'b0;
    logic [DATA_W-1:0] inj_d   = '0;
    logic              exp_ovf;
    logic              exp_unexp;
    int                kidx = 0;
    int                cyc = 0;
    int                fires = 0;
    int                fires_before;
    int                first_fire;
    int                first_valid;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic int pipe_cnt();
        int n = 0;
        for (int i = 0; i < LATENCY; i++) n += pipe_v[i] ? 1 : 0;
        return n;
    endfunction

    // Called at a falling edge with issue_valid/m_ready already set; returns at the next falling edge.
    task automatic step();
        int inf;
        bit exp_rdy;
        fma_out_valid = mdl_v | inj_v;
        fma_out       = inj_v ? inj_d : mdl_d;
        #1;
        inf     = pipe_cnt();
        exp_rdy = (exp_q.size() + inf) < DEPTH;
        check("count", count, exp_q.size());
        check("inflight", inflight, inf);
        check("issue_ready", issue_ready, exp_rdy);
        check("fma_in_valid", fma_in_valid, issue_valid & exp_rdy);
        check("m_valid", m_valid, exp_q.size() != 0);
        check("err_overflow", err_overflow, exp_ovf);
        check("err_unexpected", err_unexpected, exp_unexp);
        if (m_valid && m_ready && exp_q.size() != 0) check("m_data", m_data, exp_q.pop_front());
        if (m_valid && first_valid < 0) first_valid = cyc;
        if (mdl_v || (inj_v && inj_acc)) exp_q.push_back(fma_out);
        for (int i = LATENCY - 1; i > 0; i--) begin
            pipe_v[i] = pipe_v[i-1];
            pipe_d[i] = pipe_d[i-1];
        end
        pipe_v[0] = fma_in_valid;
        pipe_d[0] = DATA_W'(16'h3C00 + kidx);
        if (fma_in_valid) begin
            kidx++;
            fires++;
            if (first_fire < 0) first_fire = cyc;
        end
        mdl_v = pipe_v[LATENCY-1];
        mdl_d = pipe_d[LATENCY-1];
        inj_v = 1'b0;
        cyc++;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst           = 1'b1;
        issue_valid   = 1'b0;
        m_ready       = 1'b0;
        fma_out_valid = 1'b0;
        inj_v         = 1'b0;
        mdl_v         = 1'b0;
        mdl_d         = '0;
        for (int i = 0; i < LATENCY; i++) begin
            pipe_v[i] = 1'b0;
            pipe_d[i] = '0;
        end
        exp_q.delete();
        exp_ovf   = 1'b0;
        exp_unexp = 1'b0;
        first_fire  = -1;
        first_valid = -1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic run_stream(input string tag);
        first_fire  = -1;
        first_valid = -1;
        issue_valid = 1'b1;
        m_ready     = 1'b1;
        for (int i = 0; i < 20; i++) begin
            check({tag, "_count_le1"}, count <= 1, 1);
            check({tag, "_ready_high"}, issue_ready, 1);
            step();
        end
        issue_valid = 1'b0;
        repeat (8) step();
        check({tag, "_first_valid_latency"}, first_valid - first_fire, LATENCY + 1);
        check({tag, "_drained_count"}, count, 0);
        check({tag, "_scoreboard_empty"}, exp_q.size(), 0);
    endtask

    initial begin
        @(negedge clk);
        do_reset();
        check("rst_m_valid", m_valid, 0);
        check("rst_count", count, 0);
        check("rst_inflight", inflight, 0);
        check("rst_issue_ready", issue_ready, 1);
        check("rst_fma_in_valid", fma_in_valid, 0);
        check("rst_errors", {err_overflow, err_unexpected}, 0);

        // 1: steady stream
        run_stream("t1");

        // 2: backpressure fill from a clean state
        do_reset();
        fires       = 0;
        issue_valid = 1'b1;
        m_ready     = 1'b0;
        repeat (14) step();
        check("t2_fires", fires, DEPTH);
        check("t2_count_full", count, DEPTH);
        check("t2_issue_ready_low", issue_ready, 0);
        check("t2_no_overflow", err_overflow, 0);

        // 3: single pop frees one credit; the refill wraps to slot 0
        m_ready = 1'b1;
        step();
        m_ready = 1'b0;
        check("t3_ready_after_pop", issue_ready, 1);
        fires_before = fires;
        step();
        issue_valid = 1'b0;
        repeat (5) step();
        check("t3_one_refill", fires - fires_before, 1);
        check("t3_count_full", count, DEPTH);

        // 4: push and pop in the same cycle while full
        m_ready = 1'b1;
        inj_v   = 1'b1;
        inj_acc = 1'b1;
        inj_d   = 16'h7777;
        step();
        exp_unexp = 1'b1;
        check("t4_count_stays_full", count, DEPTH);
        check("t4_no_overflow", err_overflow, 0);
        repeat (10) step();
        check("t4_drained", count, 0);

        // 5: unexpected return, then overflow with the dropped value never surfacing
        do_reset();
        inj_v   = 1'b1;
        inj_acc = 1'b1;
        inj_d   = 16'hBEEF;
        step();
        exp_unexp = 1'b1;
        check("t5_unexpected_set", err_unexpected, 1);
        check("t5_inflight_zero", inflight, 0);
        issue_valid = 1'b1;
        repeat (14) step();
        issue_valid = 1'b0;
        check("t5_count_full", count, DEPTH);
        inj_v   = 1'b1;
        inj_acc = 1'b0;
        inj_d   = 16'hDEAD;
        step();
        exp_ovf = 1'b1;
        check("t5_overflow_set", err_overflow, 1);
        check("t5_count_after_drop", count, DEPTH);
        m_ready = 1'b1;
        repeat (10) step();
        check("t5_drained", count, 0);
        check("t5_scoreboard_empty", exp_q.size(), 0);

        // 6: asynchronous reset between edges with count=3, inflight=2
        m_ready     = 1'b0;
        issue_valid = 1'b1;
        repeat (5) step();
        issue_valid = 1'b0;
        repeat (2) step();
        check("t6_pre_count", count, 3);
        check("t6_pre_inflight", inflight, 2);
        #2;
        rst = 1'b1;
        #1;
        check("t6_async_count", count, 0);
        check("t6_async_inflight", inflight, 0);
        check("t6_async_m_valid", m_valid, 0);
        check("t6_async_err_overflow", err_overflow, 0);
        check("t6_async_err_unexpected", err_unexpected, 0);
        do_reset();
        run_stream("t6");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
